mux_n_scan: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer; successor to the lab 2:1 mux.
- Adds two select modes:
  - manual: select loaded by the host.
  - auto-scan: round-robin over all channels, DWELL cycles per channel.
- Adds a registered output with valid, a scan-wrap pulse and an illegal-select error pulse.
- Sits between the multi-channel data sources and a single downstream consumer, e.g. a monitor or serializer.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_dwell_ctr.sv | 40 ++++
 rtl/mux_n_scan.sv | 126 ++++++++++++
 tb/tb_mux_n_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel scanning multiplexer.
//   MODE_MAN / MODE_SCAN : encodings of the mode input
//   state_e              : operating state derived each clock from enable/mode
package mux_pkg;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAN  = 2'd1,
      ST_SCAN = 2'd2
   } state_e;

endpackage

// File: rtl/mux_dwell_ctr.sv
// Dwell counter for scan mode: counts 0 .. DWELL-1 while run is high and
// flags the last count so the select can advance.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (count -> 0)
//   run   : advance the count this cycle
//   clear : force the count back to 0 (wins over run)
//   done  : high while running at count DWELL-1
module mux_dwell_ctr #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic done
);

   // A single-cycle dwell still needs a 1-bit register to stay legal.
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int LASTI = DWELL - 1;
   localparam logic [CNT_W-1:0] LAST = LASTI[CNT_W-1:0];

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (run)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign done = run && (cnt_q == LAST);

endmodule

// File: rtl/mux_n_scan.sv
// N-channel, W-bit registered multiplexer with manual and round-robin scan
// select modes.
//   clk, rst   : clock / asynchronous active-high reset
//   din        : flattened inputs, channel k at [k*WIDTH +: WIDTH]
//   enable     : 0 freezes select, dwell count and dout
//   mode       : MODE_MAN (host select) or MODE_SCAN (round-robin)
//   sel_in     : requested channel, loaded when sel_load is high
//   dout       : registered data of the select in effect before the edge
//   dout_valid : dout was updated at the last edge
//   cur_sel    : current select register
//   wrap       : one-cycle pulse when scan goes from CHANNELS-1 back to 0
//   sel_err    : one-cycle pulse on a load of an out-of-range channel
module mux_n_scan
   import mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      sel_load,
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_valid,
   output logic [SEL_W-1:0]          cur_sel,
   output logic                      wrap,
   output logic                      sel_err
);

   localparam int LASTI = CHANNELS - 1;
   localparam logic [SEL_W-1:0] LAST_CH = LASTI[SEL_W-1:0];
   // One extra bit so the range check also works for power-of-2 counts.
   localparam logic [SEL_W:0]   NUM_CH  = CHANNELS[SEL_W:0];

   state_e           state_q, state_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [WIDTH-1:0] dout_q, dout_d, sel_data;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             sel_err_q, sel_err_d;
   logic             sel_legal, load_req, jump, advance;
   logic             dw_run, dw_clear, dw_done;

   // Data of the select in effect this cycle; compare-based so that
   // unused select codes of a non-power-of-2 build read as zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CHANNELS; k++)
         if (cur_sel_q == SEL_W'(k)) sel_data = din[k*WIDTH +: WIDTH];
   end

   always_comb begin
      state_d = ST_IDLE;
      if (enable) state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MAN;

      sel_legal = ({1'b0, sel_in} < NUM_CH);
      load_req  = (state_d != ST_IDLE) && sel_load;
      jump      = load_req && sel_legal;
      sel_err_d = load_req && !sel_legal;
      // A legal jump overrides the end-of-dwell advance.
      advance   = (state_d == ST_SCAN) && dw_done && !jump;

      // Dwell restarts on a jump and on every entry to MAN; MAN then holds it
      // at 0, so SCAN always starts fresh after MAN. IDLE keeps the count.
      dw_run   = (state_d == ST_SCAN);
      dw_clear = jump || ((state_d == ST_MAN) && (state_q != ST_MAN));

      cur_sel_d = cur_sel_q;
      wrap_d    = 1'b0;
      if (jump) begin
         cur_sel_d = sel_in;
      end else if (advance) begin
         if (cur_sel_q == LAST_CH) begin
            cur_sel_d = '0;
            wrap_d    = 1'b1;
         end else begin
            cur_sel_d = cur_sel_q + 1'b1;
         end
      end

      dout_d  = dout_q;
      valid_d = 1'b0;
      if (state_d != ST_IDLE) begin
         dout_d  = sel_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_sel_q <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
         sel_err_q <= sel_err_d;
      end
   end

   mux_dwell_ctr #(.DWELL(DWELL)) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .run   (dw_run),
      .clear (dw_clear),
      .done  (dw_done)
   );

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign cur_sel    = cur_sel_q;
   assign wrap       = wrap_q;
   assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_mux_n_scan.sv
module tb_mux_n_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 4-channel build
   logic [31:0] din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
   logic        enable = 1'b0, mode = 1'b0, sel_load = 1'b0;
   logic [1:0]  sel_in = '0;
   logic [7:0]  dout;
   logic        dout_valid, wrap, sel_err;
   logic [1:0]  cur_sel;

   // 3-channel build (select code 3 is illegal)
   logic [23:0] din3 = {8'hC2, 8'hB1, 8'hA0};
   logic        en3 = 1'b0, mode3 = 1'b0, load3 = 1'b0;
   logic [1:0]  sel_in3 = '0;
   logic [7:0]  dout3;
   logic        valid3, wrap3, err3;
   logic [1:0]  cur_sel3;

   int passed = 0;
   int total  = 0;

   mux_n_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut (
      .clk(clk), .rst(rst), .din(din), .enable(enable), .mode(mode),
      .sel_in(sel_in), .sel_load(sel_load), .dout(dout),
      .dout_valid(dout_valid), .cur_sel(cur_sel), .wrap(wrap), .sel_err(sel_err)
   );

   mux_n_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .din(din3), .enable(en3), .mode(mode3),
      .sel_in(sel_in3), .sel_load(load3), .dout(dout3),
      .dout_valid(valid3), .cur_sel(cur_sel3), .wrap(wrap3), .sel_err(err3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      rst = 1'b0;
      enable = 1'b1; mode = 1'b0; sel_in = 2'd1; sel_load = 1'b1;
      step();
      sel_load = 1'b0;
      step();
      // assert reset away from any edge; outputs must clear without a clock
      #2 rst = 1'b1;
      #1;
      total++; if (dout !== 8'h00) $display("FAIL rst_dout got=%h exp=00", dout); else passed++;
      total++; if (dout_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", dout_valid); else passed++;
      total++; if (cur_sel !== 2'd0) $display("FAIL rst_cur_sel got=%0d exp=0", cur_sel); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL rst_wrap got=%b exp=0", wrap); else passed++;
      total++; if (sel_err !== 1'b0) $display("FAIL rst_sel_err got=%b exp=0", sel_err); else passed++;
      #2 rst = 1'b0;
      step();
      total++; if (dout !== 8'hA0) $display("FAIL rst_first_dout got=%h exp=a0", dout); else passed++;
      total++; if (dout_valid !== 1'b1) $display("FAIL rst_first_valid got=%b exp=1", dout_valid); else passed++;
   endtask

   task automatic test_man_load();
      sel_in = 2'd2; sel_load = 1'b1;
      step();
      sel_load = 1'b0;
      total++; if (cur_sel !== 2'd2) $display("FAIL man_cur_sel got=%0d exp=2", cur_sel); else passed++;
      total++; if (dout !== 8'hA0) $display("FAIL man_dout_lag got=%h exp=a0", dout); else passed++;
      step();
      total++; if (dout !== 8'hC2) $display("FAIL man_dout got=%h exp=c2", dout); else passed++;
      total++; if (dout_valid !== 1'b1) $display("FAIL man_valid got=%b exp=1", dout_valid); else passed++;
   endtask

   task automatic test_scan_sweep();
      logic [1:0] exp_sel [14] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0};
      logic [7:0] chan    [4]  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      sel_in = 2'd0; sel_load = 1'b1;
      step();
      sel_load = 1'b0;
      mode = 1'b1;
      for (int k = 1; k < 14; k++) begin
         step();
         total++;
         if (cur_sel !== exp_sel[k]) $display("FAIL sweep_sel[%0d] got=%0d exp=%0d", k, cur_sel, exp_sel[k]);
         else passed++;
         total++;
         if (wrap !== (k == 12)) $display("FAIL sweep_wrap[%0d] got=%b exp=%b", k, wrap, (k == 12));
         else passed++;
         total++;
         if (dout !== chan[exp_sel[k-1]]) $display("FAIL sweep_dout[%0d] got=%h exp=%h", k, dout, chan[exp_sel[k-1]]);
         else passed++;
      end
   endtask

   task automatic test_jump();
      // park on channel 3 in MAN, then scan with a fresh dwell
      mode = 1'b0; sel_in = 2'd3; sel_load = 1'b1;
      step();
      sel_load = 1'b0; mode = 1'b1;
      total++; if (cur_sel !== 2'd3) $display("FAIL jump_setup got=%0d exp=3", cur_sel); else passed++;
      step();
      step();
      total++; if (cur_sel !== 2'd3) $display("FAIL jump_pre got=%0d exp=3", cur_sel); else passed++;
      // dwell is at its last count on channel 3: jump must beat the wrap
      sel_in = 2'd1; sel_load = 1'b1;
      step();
      sel_load = 1'b0;
      total++; if (cur_sel !== 2'd1) $display("FAIL jump_sel got=%0d exp=1", cur_sel); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL jump_wrap got=%b exp=0", wrap); else passed++;
      total++; if (dout !== 8'hD3) $display("FAIL jump_dout got=%h exp=d3", dout); else passed++;
      step();
      total++; if (cur_sel !== 2'd1) $display("FAIL jump_hold1 got=%0d exp=1", cur_sel); else passed++;
      step();
      total++; if (cur_sel !== 2'd1) $display("FAIL jump_hold2 got=%0d exp=1", cur_sel); else passed++;
      step();
      total++; if (cur_sel !== 2'd2) $display("FAIL jump_adv got=%0d exp=2", cur_sel); else passed++;
   endtask

   task automatic test_freeze();
      step();   // channel 2, dwell count now 1
      total++; if (cur_sel !== 2'd2) $display("FAIL frz_setup got=%0d exp=2", cur_sel); else passed++;
      enable = 1'b0; sel_in = 2'd0; sel_load = 1'b1;   // load must be ignored
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (dout !== 8'hC2) $display("FAIL frz_dout[%0d] got=%h exp=c2", k, dout); else passed++;
         total++; if (dout_valid !== 1'b0) $display("FAIL frz_valid[%0d] got=%b exp=0", k, dout_valid); else passed++;
         total++; if (cur_sel !== 2'd2) $display("FAIL frz_sel[%0d] got=%0d exp=2", k, cur_sel); else passed++;
      end
      sel_load = 1'b0; enable = 1'b1;
      step();
      total++; if (cur_sel !== 2'd2) $display("FAIL frz_resume_sel got=%0d exp=2", cur_sel); else passed++;
      total++; if (dout_valid !== 1'b1) $display("FAIL frz_resume_valid got=%b exp=1", dout_valid); else passed++;
      step();
      total++; if (cur_sel !== 2'd3) $display("FAIL frz_resume_adv got=%0d exp=3", cur_sel); else passed++;
   endtask

   task automatic test_illegal_sel();
      en3 = 1'b0; sel_in3 = 2'd3; load3 = 1'b1;
      step();
      total++; if (err3 !== 1'b0) $display("FAIL ill_disabled got=%b exp=0", err3); else passed++;
      en3 = 1'b1; mode3 = 1'b0; sel_in3 = 2'd1;
      step();
      total++; if (cur_sel3 !== 2'd1) $display("FAIL ill_load got=%0d exp=1", cur_sel3); else passed++;
      sel_in3 = 2'd3;
      step();
      load3 = 1'b0;
      total++; if (err3 !== 1'b1) $display("FAIL ill_man_err got=%b exp=1", err3); else passed++;
      total++; if (cur_sel3 !== 2'd1) $display("FAIL ill_man_sel got=%0d exp=1", cur_sel3); else passed++;
      step();
      total++; if (err3 !== 1'b0) $display("FAIL ill_man_pulse got=%b exp=0", err3); else passed++;
      // scan: illegal load at end of dwell still lets the advance happen
      mode3 = 1'b1;
      step();
      step();
      sel_in3 = 2'd3; load3 = 1'b1;
      step();
      load3 = 1'b0;
      total++; if (err3 !== 1'b1) $display("FAIL ill_scan_err got=%b exp=1", err3); else passed++;
      total++; if (cur_sel3 !== 2'd2) $display("FAIL ill_scan_adv got=%0d exp=2", cur_sel3); else passed++;
      step();
      total++; if (err3 !== 1'b0) $display("FAIL ill_scan_pulse got=%b exp=0", err3); else passed++;
      step();
      step();
      total++; if (cur_sel3 !== 2'd0) $display("FAIL ill_wrap_sel got=%0d exp=0", cur_sel3); else passed++;
      total++; if (wrap3 !== 1'b1) $display("FAIL ill_wrap got=%b exp=1", wrap3); else passed++;
      total++; if (dout3 !== 8'hC2) $display("FAIL ill_wrap_dout got=%h exp=c2", dout3); else passed++;
   endtask

   initial begin
      test_reset();
      test_man_load();
      test_scan_sweep();
      test_jump();
      test_freeze();
      test_illegal_sel();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
